// File: rtl/irrigation_pkg.sv
// Shared types and defaults for the irrigation valve controller.
// State encoding plus the counter-width helper used by pulse_to_level.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SPRINKLE = 2'd1,
    DRIP     = 2'd2,
    GUARD    = 2'd3
  } p2l_state_e;

  localparam int unsigned GUARD_CYCLES_DEF  = 8;
  localparam int unsigned MAX_ON_CYCLES_DEF = 1000;

  // One spare bit so the largest load value never touches the sign/overflow edge.
  function automatic int cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/pulse_to_level_if.sv
// Request/status bundle between an irrigation supervisor and pulse_to_level.
// The slave side is the valve controller; the master side issues requests.
interface pulse_to_level_if;
  import irrigation_pkg::*;

  logic pulse_as;
  logic pulse_gt;
  logic pulse_stop;
  logic tank_low;
  logic valve_as;
  logic valve_gt;
  logic busy;
  logic rej;
  logic tmo;

  modport master (
    output pulse_as, pulse_gt, pulse_stop, tank_low,
    input  valve_as, valve_gt, busy, rej, tmo
  );

  modport slave (
    input  pulse_as, pulse_gt, pulse_stop, tank_low,
    output valve_as, valve_gt, busy, rej, tmo
  );

endinterface

// File: rtl/p2l_timer.sv
// Loadable saturating down-counter with a zero flag.
// Load has priority over decrement; the count sticks at zero instead of wrapping.
module p2l_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_to_level.sv
// Converts one-cycle valve requests into registered valve levels with a post-close guard.
// Optional feature: define P2L_TIMEOUT_EN to force-close a valve after MAX_ON_CYCLES.
module pulse_to_level
  import irrigation_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES  = GUARD_CYCLES_DEF,
  parameter int unsigned MAX_ON_CYCLES = MAX_ON_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  pulse_to_level_if.slave   bus
);

  localparam int CNT_W = cnt_width(GUARD_CYCLES, MAX_ON_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  p2l_state_e state, state_nxt;
  logic       rej_nxt;
  logic       start;
  logic       active;
  logic       guard_load;
  logic       guard_zero;

  logic       valve_as_q;
  logic       valve_gt_q;
  logic       busy_q;
  logic       rej_q;

  assign start      = bus.pulse_as | bus.pulse_gt;
  assign active     = (state == SPRINKLE) || (state == DRIP);
  assign guard_load = (state_nxt == GUARD) && (state != GUARD);

  p2l_timer #(.CNT_W(CNT_W)) u_guard_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (guard_load),
    .load_val (GUARD_LOAD),
    .en       (state == GUARD),
    .zero     (guard_zero)
  );

`ifdef P2L_TIMEOUT_EN
  localparam logic [CNT_W-1:0] ON_LOAD = CNT_W'(MAX_ON_CYCLES - 1);

  logic on_load;
  logic on_zero;
  logic tmo_nxt;
  logic tmo_q;

  // Counting down from MAX_ON_CYCLES-1 hits zero on the last permitted open cycle.
  assign on_load = ((state_nxt == SPRINKLE) || (state_nxt == DRIP)) && !active;

  p2l_timer #(.CNT_W(CNT_W)) u_on_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (on_load),
    .load_val (ON_LOAD),
    .en       (active),
    .zero     (on_zero)
  );
`endif

  always_comb begin
    state_nxt = state;
    rej_nxt   = 1'b0;
`ifdef P2L_TIMEOUT_EN
    tmo_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (bus.tank_low) begin
            rej_nxt = 1'b1;
          end else if (bus.pulse_as) begin
            state_nxt = SPRINKLE;
            rej_nxt   = bus.pulse_gt;
          end else begin
            state_nxt = DRIP;
          end
        end
      end
      SPRINKLE, DRIP: begin
        rej_nxt = start;
        // A close request or dry tank outranks the timeout in the same cycle.
        if (bus.pulse_stop || bus.tank_low) begin
          state_nxt = GUARD;
        end
`ifdef P2L_TIMEOUT_EN
        else if (on_zero) begin
          state_nxt = GUARD;
          tmo_nxt   = 1'b1;
        end
`endif
      end
      GUARD: begin
        rej_nxt = start;
        if (guard_zero) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valve_as_q <= 1'b0;
      valve_gt_q <= 1'b0;
      busy_q     <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      valve_as_q <= (state_nxt == SPRINKLE);
      valve_gt_q <= (state_nxt == DRIP);
      busy_q     <= (state_nxt != IDLE);
      rej_q      <= rej_nxt;
    end
  end

`ifdef P2L_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_nxt;
    end
  end

  assign bus.tmo = tmo_q;
`else
  assign bus.tmo = 1'b0;
`endif

  assign bus.valve_as = valve_as_q;
  assign bus.valve_gt = valve_gt_q;
  assign bus.busy     = busy_q;
  assign bus.rej      = rej_q;

endmodule

// File: tb/tb_pulse_to_level.sv
// Directed self-checking bench for pulse_to_level (GUARD_CYCLES=8, MAX_ON_CYCLES=10).
// Expectations for the forced-close case follow whether P2L_TIMEOUT_EN is defined.
module tb_pulse_to_level;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pulse_to_level_if bus ();

  pulse_to_level #(
    .GUARD_CYCLES  (8),
    .MAX_ON_CYCLES (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic as, input logic gt, input logic stop, input logic tl);
    bus.pulse_as   = as;
    bus.pulse_gt   = gt;
    bus.pulse_stop = stop;
    bus.tank_low   = tl;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && bus.busy; i++) tick();
    check(tag, bus.busy, 0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("rst_valve_as", bus.valve_as, 0);
    check("rst_valve_gt", bus.valve_gt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rej", bus.rej, 0);
    check("rst_tmo", bus.tmo, 0);

    // Basic sprinkle cycle: start at cycle 5, stop at 20, idle again at 29.
    rst = 1'b0;
    for (int c = 0; c < 36; c++) begin
      check("seq_valve_as", bus.valve_as, (c >= 6 && c <= 20) ? 1 : 0);
      check("seq_busy", bus.busy, (c >= 6 && c <= 28) ? 1 : 0);
      drive(c == 5, 0, c == 20, 0);
      tick();
    end

    // Simultaneous starts: sprinkler wins, drip rejected for one cycle.
    drive(1, 1, 0, 0);
    tick();
    check("both_valve_as", bus.valve_as, 1);
    check("both_valve_gt", bus.valve_gt, 0);
    check("both_rej", bus.rej, 1);
    drive(0, 0, 0, 0);
    tick();
    check("both_rej_clear", bus.rej, 0);
    check("both_valve_hold", bus.valve_as, 1);

    // Start while active: no switch, rejected.
    drive(0, 1, 0, 0);
    tick();
    check("act_rej", bus.rej, 1);
    check("act_valve_as", bus.valve_as, 1);
    check("act_valve_gt", bus.valve_gt, 0);
    drive(0, 0, 0, 0);
    tick();
    check("act_rej_clear", bus.rej, 0);

    // Stop and start same cycle: stop wins, rej still pulses.
    drive(1, 0, 1, 0);
    tick();
    check("stopwin_valve_as", bus.valve_as, 0);
    check("stopwin_busy", bus.busy, 1);
    check("stopwin_rej", bus.rej, 1);

    // Guard: start rejected, stop ignored, exactly 8 cycles long.
    drive(1, 0, 0, 0);
    tick();
    check("guard_rej", bus.rej, 1);
    check("guard_busy", bus.busy, 1);
    check("guard_valve_as", bus.valve_as, 0);
    drive(0, 0, 1, 0);
    tick();
    check("guard_stop_rej", bus.rej, 0);
    drive(0, 0, 0, 0);
    repeat (4) tick();
    tick();
    check("guard_last_busy", bus.busy, 1);
    tick();
    check("guard_done_busy", bus.busy, 0);

    // Stop in idle does nothing.
    drive(0, 0, 1, 0);
    tick();
    check("idle_stop_busy", bus.busy, 0);
    check("idle_stop_rej", bus.rej, 0);

    // Low tank blocks drip start; low tank during drip closes it.
    drive(0, 1, 0, 1);
    tick();
    check("low_valve_gt", bus.valve_gt, 0);
    check("low_rej", bus.rej, 1);
    check("low_busy", bus.busy, 0);
    drive(0, 0, 0, 1);
    tick();
    check("low_rej_clear", bus.rej, 0);
    drive(0, 1, 0, 0);
    tick();
    check("drip_valve_gt", bus.valve_gt, 1);
    check("drip_valve_as", bus.valve_as, 0);
    drive(0, 0, 0, 0);
    tick();
    tick();
    check("drip_hold", bus.valve_gt, 1);
    drive(0, 0, 0, 1);
    tick();
    check("drip_low_valve_gt", bus.valve_gt, 0);
    check("drip_low_busy", bus.busy, 1);
    drive(0, 0, 0, 0);
    wait_idle("drip_low_idle");

    // Long drip: forced close after 10 cycles, or held open without the timeout.
    drive(0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    n = 0;
`ifdef P2L_TIMEOUT_EN
    while (bus.valve_gt && n < 250) begin
      check("to_tmo_low", bus.tmo, 0);
      n++;
      tick();
    end
    check("to_open_cycles", n, 10);
    check("to_tmo_pulse", bus.tmo, 1);
    check("to_busy", bus.busy, 1);
    tick();
    check("to_tmo_clear", bus.tmo, 0);
`else
    repeat (200) begin
      if (bus.valve_gt) n++;
      tick();
    end
    check("noto_open_cycles", n, 200);
    check("noto_still_open", bus.valve_gt, 1);
    check("noto_tmo", bus.tmo, 0);
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    check("noto_closed", bus.valve_gt, 0);
`endif
    wait_idle("long_idle");

    // Reset mid-sprinkle; pulse during reset is discarded.
    drive(1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    check("pre_rst_valve_as", bus.valve_as, 1);
    rst = 1'b1;
    drive(1, 0, 0, 0);
    tick();
    check("rst_mid_valve_as", bus.valve_as, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_rej", bus.rej, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    check("rst_discard_valve_as", bus.valve_as, 0);
    check("rst_discard_busy", bus.busy, 0);

    // Reset mid-guard; first pulse after release is accepted.
    drive(1, 0, 0, 0);
    tick();
    check("g_open", bus.valve_as, 1);
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    check("g_in_guard", bus.busy, 1);
    rst = 1'b1;
    tick();
    check("rst_guard_busy", bus.busy, 0);
    check("rst_guard_valve_as", bus.valve_as, 0);
    rst = 1'b0;
    drive(1, 0, 0, 0);
    tick();
    check("post_rst_valve_as", bus.valve_as, 1);
    check("post_rst_busy", bus.busy, 1);
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0);
    wait_idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
